// File: rtl/piso_shift_param.sv
// piso_shift_param
// Parallel-in/serial-out shift register. It accepts a word through a load
// handshake and then streams the word out one bit at a time. The bit order
// is selectable, shift_en can stall the output, and a new word can follow
// the previous one with no idle cycle between them.
//
// Parameters
//   WIDTH      : word width in bits, legal range 2..32
//   MSB_FIRST  : 1 sends parallel_in[WIDTH-1] first, 0 sends parallel_in[0] first
//   IDLE_LEVEL : level driven on serial_out while no word is active
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   load         : request to accept parallel_in
//   load_ready   : a word can be accepted on this edge (combinational)
//   parallel_in  : word to serialise, sampled only on an accepted load
//   shift_en     : advance enable; 0 holds the current bit
//   serial_out   : current serial bit (registered)
//   serial_valid : serial_out carries a word bit (registered)
//   last         : current bit is the final bit of the word
//   bit_cnt      : index of the current bit within the word, 0 = first bit
//   done         : one-cycle pulse after the final bit has been consumed
module piso_shift_param #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         parallel_in,
  input  logic                     shift_en,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     last,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     done
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             final_bit;
  logic             accept;
  logic             consume;

  assign serial_valid = (state_q == ST_SHIFT);
  assign final_bit    = serial_valid && (cnt_q == LAST_IDX);
  assign last         = final_bit;
  // A new word may enter on the same edge that consumes the final bit.
  // This lets words stream back to back with no idle cycle.
  assign load_ready   = !serial_valid || (final_bit && shift_en);
  assign accept       = load && load_ready;
  assign consume      = serial_valid && shift_en;

  assign serial_out   = sout_q;
  assign bit_cnt      = cnt_q;
  assign done         = done_q;

  // The bit on serial_out is always at the output end of the register.
  // Shifting moves the next bit into that position.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (consume) begin
      sreg_d = sreg_shifted;
      if (final_bit) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // An accept takes priority over the return to IDLE on the final-bit edge.
    if (accept) begin
      sreg_d  = parallel_in;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end

    // serial_out is registered, so it is taken from the next register value.
    if (state_d == ST_SHIFT) begin
      sout_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
    end else begin
      sout_d = IDLE_LEVEL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// tb_piso_shift_param
// Three instances share one stimulus stream:
//   dut0: WIDTH=4, MSB first, idle level 0
//   dut1: WIDTH=4, LSB first, idle level 1
//   dut2: WIDTH=8, MSB first, idle level 0
// Each instance has a model built from a per-word count of remaining bits.
// Each accepted word pushes its expected bit sequence into that instance's
// FIFO. The monitor compares the presented bit with the head of the FIFO and
// pops the entry when the bit is consumed.
module tb_piso_shift_param;

  localparam int unsigned WA   [3] = '{4, 4, 8};
  localparam bit          MSBA [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit          IDLA [3] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned FD       = 64;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       shift_en;
  logic [7:0] pdata;

  logic       so0, so1, so2;
  logic       sv0, sv1, sv2;
  logic       ls0, ls1, ls2;
  logic       dn0, dn1, dn2;
  logic       lr0, lr1, lr2;
  logic [1:0] bc0, bc1;
  logic [2:0] bc2;

  logic [2:0]  so_v, sv_v, ls_v, dn_v, lr_v;
  int unsigned bc_a [3];

  assign so_v = {so2, so1, so0};
  assign sv_v = {sv2, sv1, sv0};
  assign ls_v = {ls2, ls1, ls0};
  assign dn_v = {dn2, dn1, dn0};
  assign lr_v = {lr2, lr1, lr0};

  always_comb begin
    bc_a[0] = 32'(bc0);
    bc_a[1] = 32'(bc1);
    bc_a[2] = 32'(bc2);
  end

  piso_shift_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_ready(lr0),
    .parallel_in(pdata[3:0]), .shift_en(shift_en), .serial_out(so0),
    .serial_valid(sv0), .last(ls0), .bit_cnt(bc0), .done(dn0)
  );

  piso_shift_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_ready(lr1),
    .parallel_in(pdata[3:0]), .shift_en(shift_en), .serial_out(so1),
    .serial_valid(sv1), .last(ls1), .bit_cnt(bc1), .done(dn1)
  );

  piso_shift_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_ready(lr2),
    .parallel_in(pdata), .shift_en(shift_en), .serial_out(so2),
    .serial_valid(sv2), .last(ls2), .bit_cnt(bc2), .done(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and expected-bit FIFOs, one per instance.
  int unsigned rem      [3];
  bit          exp_done [3];
  bit          fbit     [3][FD];
  int unsigned fidx     [3][FD];
  int unsigned hd       [3];
  int unsigned tl       [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input int unsigned dut,
                     input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, dut, act, exp, $time);
    end
  endtask

  task automatic push_word(input int unsigned i, input logic [7:0] d);
    int unsigned pos;
    for (int unsigned k = 0; k < WA[i]; k++) begin
      pos = MSBA[i] ? (WA[i] - 1 - k) : k;
      fbit[i][tl[i] % FD] = d[pos];
      fidx[i][tl[i] % FD] = k;
      tl[i]++;
    end
  endtask

  // Called at a negedge. Drives the inputs, advances the model across the
  // next posedge, and returns at the following negedge.
  task automatic step(input bit ld, input bit se, input logic [7:0] d);
    bit rdy;
    bit dnx;
    load     = ld;
    shift_en = se;
    pdata    = d;
    @(posedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      rdy = (rem[i] == 0) || (rem[i] == 1 && se);
      dnx = 1'b0;
      if (rem[i] > 0 && se) begin
        rem[i]--;
        if (rem[i] == 0) dnx = 1'b1;
      end
      if (ld && rdy) begin
        push_word(i, d);
        rem[i] = WA[i];
      end
      exp_done[i] = dnx;
    end
    @(negedge clk);
  endtask

  // Reset lands mid-cycle. The outputs must clear at once, and the word in
  // progress is discarded.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    for (int unsigned i = 0; i < 3; i++) begin
      chk("rst_valid", i, sv_v[i], 0);
      chk("rst_out",   i, so_v[i], IDLA[i]);
      chk("rst_cnt",   i, bc_a[i], 0);
      chk("rst_done",  i, dn_v[i], 0);
      chk("rst_last",  i, ls_v[i], 0);
      chk("rst_ready", i, lr_v[i], 1);
      tl[i]       = hd[i];
      rem[i]      = 0;
      exp_done[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle, just after the negedge.
  initial begin
    int unsigned cnt;
    int unsigned slot;
    forever begin
      @(negedge clk);
      #1;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt = tl[i] - hd[i];
        chk("valid", i, sv_v[i], (cnt > 0) ? 1 : 0);
        chk("load_ready", i, lr_v[i], ((cnt == 0) || (cnt == 1 && shift_en)) ? 1 : 0);
        chk("done", i, dn_v[i], exp_done[i]);
        if (cnt > 0) begin
          slot = hd[i] % FD;
          chk("serial_out", i, so_v[i], fbit[i][slot]);
          chk("bit_cnt", i, bc_a[i], fidx[i][slot]);
          chk("last", i, ls_v[i], (fidx[i][slot] == WA[i] - 1) ? 1 : 0);
          if (shift_en) hd[i]++;
        end else begin
          chk("idle_out", i, so_v[i], IDLA[i]);
          chk("idle_last", i, ls_v[i], 0);
        end
      end
    end
  end

  initial begin
    bit         ld;
    bit         se;
    logic [7:0] d;
    rst_n    = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    pdata    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      rem[i] = 0; exp_done[i] = 1'b0; hd[i] = 0; tl[i] = 0;
    end

    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("por_valid", i, sv_v[i], 0);
      chk("por_out",   i, so_v[i], IDLA[i]);
      chk("por_ready", i, lr_v[i], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, 1011 for the 4-bit instances.
    step(1'b1, 1'b1, 8'hAB);
    repeat (10) step(1'b0, 1'b1, 8'h00);

    // Back-to-back: the second load is held until it is accepted.
    step(1'b1, 1'b1, 8'hAB);
    repeat (4) step(1'b1, 1'b1, 8'h66);
    repeat (12) step(1'b0, 1'b1, 8'h00);

    // A load in the middle of an active word is ignored.
    step(1'b1, 1'b1, 8'hAB);
    step(1'b1, 1'b1, 8'h00);
    repeat (12) step(1'b0, 1'b1, 8'h00);

    // Stall the 8-bit instance on bit 2 of A5.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    repeat (3) begin
      step(1'b0, 1'b0, 8'h00);
      chk("stall_bit", 2, so2, 1);
      chk("stall_cnt", 2, 32'(bc2), 2);
    end
    repeat (12) step(1'b0, 1'b1, 8'h00);

    // Reset after bit 1, then load 1100.
    step(1'b1, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 8'h00);
    do_reset();
    step(1'b1, 1'b1, 8'hCC);
    repeat (12) step(1'b0, 1'b1, 8'h00);

    // Random traffic with occasional resets.
    repeat (1500) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        ld = ($urandom_range(0, 1) == 1);
        se = ($urandom_range(0, 3) != 0);
        d  = 8'($urandom);
        step(ld, se, d);
      end
    end

    repeat (12) step(1'b0, 1'b1, 8'h00);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("drain_empty", i, tl[i] - hd[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
